// File: rtl/glitch_cmd_parser.sv
// UART command parser for the glitcher: decodes d/w/a/s commands, holds config.
// Optional inter-byte argument timeout: define GLITCH_CMD_TIMEOUT_EN.
module glitch_cmd_parser #(
   parameter int DELAY_W        = 16,
   parameter int WIDTH_W        = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   input  logic               busy_in,
   output logic [DELAY_W-1:0] delay,
   output logic [WIDTH_W-1:0] pulse_width,
   output logic               arm,
   output logic               rx_drop
);

   localparam int NB = DELAY_W / 8;
   localparam int CW = $clog2(NB + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARG, S_RESP} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               tgt_q, tgt_d;
   logic [DELAY_W-1:0] shadow_q, shadow_d, shadow_nx;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [WIDTH_W-1:0] width_q, width_d;
   logic               arm_q, arm_d;
   logic [7:0]         txd_q, txd_d;
   logic               drop_q, drop_d;

`ifdef GLITCH_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`else
   logic unused_tmo;
   assign unused_tmo = |TIMEOUT_CYCLES;
`endif

   assign shadow_nx = (shadow_q << 8) | DELAY_W'(rx_data);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tgt_d    = tgt_q;
      shadow_d = shadow_q;
      delay_d  = delay_q;
      width_d  = width_q;
      arm_d    = 1'b0;
      txd_d    = txd_q;
      drop_d   = 1'b0;
`ifdef GLITCH_CMD_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif
      unique case (state_q)
         S_IDLE: begin
`ifdef GLITCH_CMD_TIMEOUT_EN
            tmo_d = '0;
`endif
            if (rx_valid) begin
               state_d  = S_RESP;
               shadow_d = '0;
               case (rx_data)
                  8'h64: begin
                     state_d = S_ARG;
                     cnt_d   = CW'(NB);
                     tgt_d   = 1'b0;
                  end
                  8'h77: begin
                     state_d = S_ARG;
                     cnt_d   = CW'(1);
                     tgt_d   = 1'b1;
                  end
                  8'h61: begin
                     if (busy_in)
                        txd_d = 8'h42;
                     else if (width_q == '0)
                        txd_d = 8'h45;
                     else begin
                        arm_d = 1'b1;
                        txd_d = 8'h2E;
                     end
                  end
                  8'h73:   txd_d = {7'b0, busy_in};
                  default: txd_d = 8'h3F;
               endcase
            end
         end
         S_ARG: begin
            if (rx_valid) begin
               shadow_d = shadow_nx;
               cnt_d    = cnt_q - CW'(1);
`ifdef GLITCH_CMD_TIMEOUT_EN
               tmo_d    = '0;
`endif
               if (cnt_q == CW'(1)) begin
                  state_d = S_RESP;
                  txd_d   = 8'h2E;
                  if (tgt_q)
                     width_d = shadow_nx[WIDTH_W-1:0];
                  else
                     delay_d = shadow_nx;
               end
            end
`ifdef GLITCH_CMD_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d  = S_RESP;
               txd_d    = 8'h21;
               shadow_d = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         S_RESP: begin
            // bytes arriving while a response is pending are lost
            drop_d = rx_valid;
            if (tx_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tgt_q    <= 1'b0;
         shadow_q <= '0;
         delay_q  <= '0;
         width_q  <= '0;
         arm_q    <= 1'b0;
         txd_q    <= 8'h00;
         drop_q   <= 1'b0;
`ifdef GLITCH_CMD_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tgt_q    <= tgt_d;
         shadow_q <= shadow_d;
         delay_q  <= delay_d;
         width_q  <= width_d;
         arm_q    <= arm_d;
         txd_q    <= txd_d;
         drop_q   <= drop_d;
`ifdef GLITCH_CMD_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   assign tx_valid    = (state_q == S_RESP);
   assign tx_data     = txd_q;
   assign delay       = delay_q;
   assign pulse_width = width_q;
   assign arm         = arm_q;
   assign rx_drop     = drop_q;

endmodule

// File: tb/tb_glitch_cmd_parser.sv
// Scoreboard bench for glitch_cmd_parser: expected responses queued per command.
module tb_glitch_cmd_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy_in = 1'b0;
   logic [15:0] delay;
   logic [7:0]  pulse_width;
   logic        arm;
   logic        rx_drop;

   int tests = 0;
   int fails = 0;
   int arm_cnt = 0;
   logic [7:0] exp_q[$];

   glitch_cmd_parser #(
      .DELAY_W(16),
      .WIDTH_W(8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy_in(busy_in),
      .delay(delay),
      .pulse_width(pulse_width),
      .arm(arm),
      .rx_drop(rx_drop)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && arm) arm_cnt++;

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      logic [7:0] e;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         if (tx_valid && tx_ready) begin
            e = exp_q.pop_front();
            tests++;
            if (tx_data !== e) begin
               fails++;
               $display("FAIL resp: got %h expected %h", tx_data, e);
            end
         end
         n++;
      end
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL resp_timeout: %0d responses missing, expected 0",
                  exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({delay, pulse_width, arm, tx_valid, tx_data, rx_drop} !== 35'h0) begin
         fails++;
         $display("FAIL reset: got d=%h w=%h a=%b v=%b t=%h r=%b expected zeros",
                  delay, pulse_width, arm, tx_valid, tx_data, rx_drop);
      end
      rst = 1'b0;
   endtask

   task automatic test_delay;
      tx_ready = 1'b1;
      send(8'h64);
      send(8'h12);
      tests++;
      if (delay !== 16'h0) begin
         fails++;
         $display("FAIL delay_partial: got %h expected 0000", delay);
      end
      exp_q.push_back(8'h2E);
      send(8'h34);
      tests++;
      if (delay !== 16'h1234 || tx_valid !== 1'b1 || tx_data !== 8'h2E) begin
         fails++;
         $display("FAIL delay_commit: got d=%h v=%b t=%h expected 1234 1 2e",
                  delay, tx_valid, tx_data);
      end
      wait_drain(10);
      @(posedge clk); #1;
      tests++;
      if (tx_valid !== 1'b0) begin
         fails++;
         $display("FAIL delay_txdrop: got %b expected 0", tx_valid);
      end
   endtask

   task automatic test_width_zero;
      int a0;
      exp_q.push_back(8'h2E);
      send(8'h77);
      send(8'h00);
      wait_drain(10);
      tests++;
      if (pulse_width !== 8'h00) begin
         fails++;
         $display("FAIL width_zero: got %h expected 00", pulse_width);
      end
      a0 = arm_cnt;
      exp_q.push_back(8'h45);
      send(8'h61);
      wait_drain(10);
      repeat (3) @(posedge clk);
      tests++;
      if (arm_cnt !== a0) begin
         fails++;
         $display("FAIL arm_width0: got %0d pulses expected %0d", arm_cnt, a0);
      end
   endtask

   task automatic test_arm;
      int a0;
      exp_q.push_back(8'h2E);
      send(8'h77);
      send(8'h05);
      wait_drain(10);
      tests++;
      if (pulse_width !== 8'h05) begin
         fails++;
         $display("FAIL width_set: got %h expected 05", pulse_width);
      end
      a0 = arm_cnt;
      exp_q.push_back(8'h2E);
      send(8'h61);
      tests++;
      if (arm !== 1'b1) begin
         fails++;
         $display("FAIL arm_pulse: got %b expected 1", arm);
      end
      wait_drain(10);
      @(posedge clk); #1;
      tests++;
      if (arm !== 1'b0 || arm_cnt !== a0 + 1) begin
         fails++;
         $display("FAIL arm_once: got arm=%b pulses=%0d expected 0 %0d",
                  arm, arm_cnt - a0, 1);
      end
      busy_in = 1'b1;
      a0 = arm_cnt;
      exp_q.push_back(8'h42);
      send(8'h61);
      wait_drain(10);
      repeat (2) @(posedge clk);
      tests++;
      if (arm_cnt !== a0) begin
         fails++;
         $display("FAIL arm_busy: got %0d pulses expected 0", arm_cnt - a0);
      end
      busy_in = 1'b0;
   endtask

   task automatic test_status_hold;
      int a0 = arm_cnt;
      busy_in  = 1'b1;
      tx_ready = 1'b0;
      exp_q.push_back(8'h01);
      send(8'h73);
      for (int i = 0; i < 10; i++) begin
         tests++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
            fails++;
            $display("FAIL status_hold[%0d]: got v=%b t=%h expected 1 01",
                     i, tx_valid, tx_data);
         end
         if (i == 4) begin
            tests++;
            if (rx_drop !== 1'b1) begin
               fails++;
               $display("FAIL drop_pulse: got %b expected 1", rx_drop);
            end
            rx_valid = 1'b0;
         end
         if (i == 5) begin
            tests++;
            if (rx_drop !== 1'b0) begin
               fails++;
               $display("FAIL drop_once: got %b expected 0", rx_drop);
            end
         end
         if (i == 3) begin
            rx_data  = 8'h61;
            rx_valid = 1'b1;
         end
         @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      wait_drain(10);
      @(posedge clk); #1;
      tests++;
      if (tx_valid !== 1'b0 || arm_cnt !== a0) begin
         fails++;
         $display("FAIL status_release: got v=%b pulses=%0d expected 0 0",
                  tx_valid, arm_cnt - a0);
      end
      busy_in = 1'b0;
   endtask

   task automatic test_back_to_back;
      exp_q.push_back(8'h3F);
      send(8'h7A);
      rx_data  = 8'h73;
      rx_valid = 1'b1;
      wait_drain(10);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      tests++;
      if (rx_drop !== 1'b1 || tx_valid !== 1'b0) begin
         fails++;
         $display("FAIL accept_drop: got drop=%b v=%b expected 1 0",
                  rx_drop, tx_valid);
      end
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (tx_valid !== 1'b0) begin
         fails++;
         $display("FAIL accept_noresp: got %b expected 0", tx_valid);
      end
   endtask

   task automatic test_reset_mid;
      send(8'h64);
      send(8'h12);
      send(8'h34);
      send(8'h64);
      send(8'hAB);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      tests++;
      if (delay !== 16'h0 || tx_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: got d=%h v=%b expected 0000 0", delay, tx_valid);
      end
      exp_q.push_back(8'h3F);
      send(8'h7A);
      tests++;
      if (tx_data !== 8'h3F) begin
         fails++;
         $display("FAIL reset_stale: got %h expected 3f", tx_data);
      end
      wait_drain(10);
      tests++;
      if (delay !== 16'h0) begin
         fails++;
         $display("FAIL reset_delay: got %h expected 0000", delay);
      end
   endtask

`ifdef GLITCH_CMD_TIMEOUT_EN
   task automatic test_timeout;
      logic [15:0] d0 = delay;
      exp_q.push_back(8'h21);
      send(8'h64);
      send(8'hAB);
      wait_drain(40);
      tests++;
      if (delay !== d0) begin
         fails++;
         $display("FAIL timeout_delay: got %h expected %h", delay, d0);
      end
      exp_q.push_back(8'h2E);
      send(8'h64);
      send(8'h00);
      send(8'h10);
      wait_drain(10);
      tests++;
      if (delay !== 16'h0010) begin
         fails++;
         $display("FAIL timeout_next: got %h expected 0010", delay);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_delay();
      test_width_zero();
      test_arm();
      test_status_hold();
      test_back_to_back();
      test_reset_mid();
`ifdef GLITCH_CMD_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
